// File: rtl/imem_responder.sv
// Instruction memory responder: preloadable word memory with a fixed-latency
// read pipeline that feeds a show-ahead response FIFO. Requests are only
// accepted while a FIFO slot is guaranteed for them (credit = in flight + buffered).
module imem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic                  err;
    logic [DATA_WIDTH-1:0] data;
  } resp_t;

  logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];
  resp_t                 r_fifo [0:FIFO_DEPTH-1];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_cnt;

  logic [ADDR_WIDTH-1:0] w_idx;
  logic [DATA_WIDTH-1:0] w_hi;
  logic                  w_fault;
  resp_t                 w_rd;
  logic                  w_acc, w_push, w_pop, w_vld;
  resp_t                 w_push_ent;
  logic [2:0]            w_inflight;
  logic [CW:0]           w_outstanding;

  // Address decode: word index from the byte PC, fault on misalignment or out-of-range.
  assign w_idx       = req_addr[ADDR_WIDTH+1:2];
  assign w_hi        = req_addr >> (ADDR_WIDTH + 2);
  assign w_fault     = (req_addr[1:0] != 2'b00) || (w_hi != '0);
  assign w_rd.err    = w_fault;
  assign w_rd.data   = w_fault ? '0 : r_mem[w_idx];

  // Credits come from registered state only, so a pop frees a slot next cycle.
  assign w_outstanding = {1'b0, r_cnt} + (CW+1)'(w_inflight);
  assign req_ready     = !rst && !load_en && (w_outstanding < (CW+1)'(FIFO_DEPTH));
  assign w_acc         = req_valid && req_ready;

  assign w_vld      = (r_cnt != '0);
  assign w_pop      = w_vld && resp_ready;
  assign resp_valid = !rst && w_vld;
  assign resp_data  = resp_valid ? r_fifo[r_rptr].data : '0;
  assign resp_err   = resp_valid ? r_fifo[r_rptr].err  : 1'b0;

  // Preload port; memory is deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (load_en) r_mem[load_addr] <= load_data;
  end

  generate
    if (LATENCY == 1) begin : g_nopipe
      // The FIFO slot itself acts as the read register.
      assign w_push     = w_acc;
      assign w_push_ent = w_rd;
      assign w_inflight = '0;
    end else begin : g_pipe
      logic [LATENCY-1:1] r_vld_pipe;
      resp_t              r_ent_pipe [LATENCY-1:1];

      // Stage 1 captures the memory read at the accept edge, later stages just delay it.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_vld_pipe <= '0;
        end else begin
          r_vld_pipe[1] <= w_acc;
          for (int k = 2; k < LATENCY; k++) r_vld_pipe[k] <= r_vld_pipe[k-1];
        end
        r_ent_pipe[1] <= w_rd;
        for (int k = 2; k < LATENCY; k++) r_ent_pipe[k] <= r_ent_pipe[k-1];
      end

      // Count live pipeline entries for the credit check.
      always_comb begin
        w_inflight = '0;
        for (int k = 1; k < LATENCY; k++) w_inflight = w_inflight + {2'b00, r_vld_pipe[k]};
      end

      assign w_push     = r_vld_pipe[LATENCY-1];
      assign w_push_ent = r_ent_pipe[LATENCY-1];
    end
  endgenerate

  // Response FIFO: pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= w_push_ent;
        r_wptr         <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // The credit rule makes a push into a full FIFO impossible; catch it if it ever happens.
  always_ff @(posedge clk) begin
    if (!rst && w_push) assert (r_cnt < CW'(FIFO_DEPTH));
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: stimulus pushes hand-computed expected
// responses, a negedge monitor pops and compares every handshaken response.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        load_en = 1'b0;
  logic [9:0]  load_addr = '0;
  logic [31:0] load_data = '0;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mem_init [0:7];

  imem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LATENCY(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted response must match the oldest expectation.
  always @(negedge clk) begin
    if (resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got data %h err %0d expected no response", resp_data, resp_err);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("resp_data", resp_data, x.d);
        chk("resp_err", {31'b0, resp_err}, {31'b0, x.e});
      end
    end
  end

  // Hold a request until accepted (bounded), recording its expected response.
  task automatic issue(input logic [31:0] addr, input logic [31:0] d, input logic e);
    bit ok = 0;
    req_valid = 1'b1;
    req_addr  = addr;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        sb.push_back('{d: d, e: e});
      end
      tick();
    end
    req_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: addr %h never accepted", addr);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || resp_valid) && t < 50) begin
      tick();
      t++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic basic_fetch(input string tag);
    resp_ready = 1'b1;
    issue(32'h0000_000C, 32'h0050_0093, 1'b0);
    @(negedge clk);
    chk({tag, "_lat1"}, {31'b0, resp_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk({tag, "_lat2"}, {31'b0, resp_valid}, 32'd1);
    tick();
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] d0;
    int          acc;

    for (int i = 0; i < 8; i++) mem_init[i] = 32'h1000_0000 | i;
    mem_init[3] = 32'h0050_0093;
    mem_init[5] = 32'hAAAA_0000;

    // Preload during reset: loads must still land.
    for (int i = 0; i < 8; i++) begin
      load_en   = 1'b1;
      load_addr = 10'(i);
      load_data = mem_init[i];
      tick();
    end
    load_en = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_data", resp_data, 32'd0);
    chk("rst_err", {31'b0, resp_err}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
    tick();

    // Basic fetch with 2-cycle latency.
    basic_fetch("basic");

    // Streaming: one response per cycle, ready never drops.
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'(i * 4);
      @(negedge clk);
      chk("stream_rdy", {31'b0, req_ready}, 32'd1);
      if (i >= 2) chk("stream_vld", {31'b0, resp_valid}, 32'd1);
      if (req_ready) sb.push_back('{d: mem_init[i], e: 1'b0});
      tick();
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("stream_tail6", {31'b0, resp_valid}, 32'd1);
    tick();
    @(negedge clk);
    chk("stream_tail7", {31'b0, resp_valid}, 32'd1);
    tick();
    @(negedge clk);
    chk("stream_done", {31'b0, resp_valid}, 32'd0);
    tick();
    drain();

    // Backpressure: only FIFO_DEPTH accepted, credit returns a cycle after the pop.
    resp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'(acc * 4);
      @(negedge clk);
      chk("bp_rdy", {31'b0, req_ready}, (i < 4) ? 32'd1 : 32'd0);
      if (req_ready) begin
        sb.push_back('{d: mem_init[acc], e: 1'b0});
        acc++;
      end
      tick();
    end
    req_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd4);
    @(negedge clk);
    d0 = resp_data;
    chk("bp_head", d0, mem_init[0]);
    tick();
    @(negedge clk);
    chk("bp_hold", resp_data, d0);
    tick();
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rdy_popcyc", {31'b0, req_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("bp_rdy_after", {31'b0, req_ready}, 32'd1);
    tick();
    drain();

    // Faults between good fetches.
    resp_ready = 1'b1;
    issue(32'h0000_0010, mem_init[4], 1'b0);
    issue(32'h0000_0002, 32'd0, 1'b1);
    issue(32'h0000_1000, 32'd0, 1'b1);
    issue(32'h0000_0014, 32'hAAAA_0000, 1'b0);
    drain();

    // Load hazard: in-flight read keeps old data, later read sees new.
    issue(32'h0000_0014, 32'hAAAA_0000, 1'b0);
    load_en   = 1'b1;
    load_addr = 10'd5;
    load_data = 32'h1234_5678;
    @(negedge clk);
    chk("ld_rdy", {31'b0, req_ready}, 32'd0);
    tick();
    load_en = 1'b0;
    issue(32'h0000_0014, 32'h1234_5678, 1'b0);
    drain();

    // Reset mid-stream: buffered and in-flight responses are discarded.
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(32'(i * 4), mem_init[i], 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_ready", {31'b0, req_ready}, 32'd0);
    chk("mrst_valid", {31'b0, resp_valid}, 32'd0);
    chk("mrst_data", resp_data, 32'd0);
    tick();
    rst = 1'b0;
    sb.delete();
    resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mrst_quiet_valid", {31'b0, resp_valid}, 32'd0);
      chk("mrst_quiet_data", resp_data, 32'd0);
      chk("mrst_quiet_err", {31'b0, resp_err}, 32'd0);
      tick();
    end
    basic_fetch("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
